// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath constants and Q-format helpers
package fft_pkg;

   localparam int RND_TRUNC     = 0;
   localparam int RND_HALF_UP   = 1;
   localparam int RND_HALF_EVEN = 2;

   // Total width of a signed Q(I).F word; I already counts the sign bit.
   function automatic int q_width(input int int_bits, input int frac_bits);
      return int_bits + frac_bits;
   endfunction

endpackage

// File: rtl/cmul_pipe_if.sv
// rtl/cmul_pipe_if.sv - operand/result bundle of the pipelined complex multiplier
interface cmul_pipe_if #(
   parameter int W = 8
);

   logic                i_en;
   logic                i_valid;
   logic                i_conj;
   logic signed [W-1:0] i_data1_re;
   logic signed [W-1:0] i_data1_im;
   logic signed [W-1:0] i_data2_re;
   logic signed [W-1:0] i_data2_im;
   logic                i_clr_ovf;

   logic                o_valid;
   logic signed [W-1:0] o_data_re;
   logic signed [W-1:0] o_data_im;
   logic                o_ovf_re;
   logic                o_ovf_im;
   logic                o_ovf_sticky;

   modport master (
      output i_en, i_valid, i_conj,
      output i_data1_re, i_data1_im, i_data2_re, i_data2_im,
      output i_clr_ovf,
      input  o_valid, o_data_re, o_data_im,
      input  o_ovf_re, o_ovf_im, o_ovf_sticky
   );

   modport slave (
      input  i_en, i_valid, i_conj,
      input  i_data1_re, i_data1_im, i_data2_re, i_data2_im,
      input  i_clr_ovf,
      output o_valid, o_data_re, o_data_im,
      output o_ovf_re, o_ovf_im, o_ovf_sticky
   );

endinterface

// File: rtl/cmul_round_sat.sv
// rtl/cmul_round_sat.sv - rounding term (stage 2) and shift/saturate (stage 3) for one component
module cmul_round_sat
   import fft_pkg::*;
#(
   parameter int W2  = 17,
   parameter int F   = 4,
   parameter int W   = 8,
   parameter int RND = RND_HALF_UP
) (
   input  logic signed [W2-1:0] sum,
   output logic signed [W2-1:0] sum_rnd,
   input  logic signed [W2-1:0] acc,
   output logic signed [W-1:0]  data,
   output logic                 ovf
);

   localparam logic signed [W2-1:0] HALF  = W2'(1) << (F - 1);
   localparam logic signed [W2-1:0] MAX_V = {{(W2-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [W2-1:0] MIN_V = {{(W2-W+1){1'b1}}, {(W-1){1'b0}}};

   logic signed [W2-1:0] rnd_term;
   logic signed [W2-1:0] sh;

   // Half-even skips the bump only on an exact tie whose kept LSB is already even.
   always_comb begin
      rnd_term = '0;
      if (RND == RND_HALF_UP) begin
         rnd_term = HALF;
      end else if (RND == RND_HALF_EVEN) begin
         if (!((sum[F-1:0] == HALF[F-1:0]) && !sum[F])) begin
            rnd_term = HALF;
         end
      end
   end

   assign sum_rnd = sum + rnd_term;
   assign sh      = acc >>> F;

   always_comb begin
      data = sh[W-1:0];
      ovf  = 1'b0;
      if (sh > MAX_V) begin
         data = MAX_V[W-1:0];
         ovf  = 1'b1;
      end else if (sh < MIN_V) begin
         data = MIN_V[W-1:0];
         ovf  = 1'b1;
      end
   end

endmodule

// File: rtl/cmul_pipe.sv
// rtl/cmul_pipe.sv - 3-stage signed Q(I).F complex multiplier with conjugate, rounding and saturation
module cmul_pipe
   import fft_pkg::*;
#(
   parameter int I   = 4,
   parameter int F   = 4,
   parameter int RND = RND_HALF_UP
) (
   input  logic       clk,
   input  logic       rst,
   cmul_pipe_if.slave bus
);

   localparam int W  = q_width(I, F);
   localparam int P  = 2 * W;
   localparam int W2 = 2 * W + 1;

   logic signed [P-1:0]  a_x, b_x, c_x, d_x;
   logic                 s1_valid, s1_conj;
   logic signed [P-1:0]  s1_ac, s1_ad, s1_bc, s1_bd;

   logic signed [W2-1:0] ac_x, ad_x, bc_x, bd_x;
   logic signed [W2-1:0] sum_re, sum_im;
   logic signed [W2-1:0] rnd_re, rnd_im;
   logic                 s2_valid;
   logic signed [W2-1:0] s2_re, s2_im;

   logic signed [W-1:0]  sat_re, sat_im;
   logic                 sat_ovf_re, sat_ovf_im;
   logic                 s3_valid;
   logic signed [W-1:0]  s3_re, s3_im;
   logic                 s3_ovf_re, s3_ovf_im;
   logic                 ovf_sticky;

   assign a_x = P'(bus.i_data1_re);
   assign b_x = P'(bus.i_data1_im);
   assign c_x = P'(bus.i_data2_re);
   assign d_x = P'(bus.i_data2_im);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_conj  <= 1'b0;
         s1_ac    <= '0;
         s1_ad    <= '0;
         s1_bc    <= '0;
         s1_bd    <= '0;
      end else if (bus.i_en) begin
         s1_valid <= bus.i_valid;
         s1_conj  <= bus.i_conj;
         s1_ac    <= a_x * c_x;
         s1_ad    <= a_x * d_x;
         s1_bc    <= b_x * c_x;
         s1_bd    <= b_x * d_x;
      end
   end

   assign ac_x = W2'(s1_ac);
   assign ad_x = W2'(s1_ad);
   assign bc_x = W2'(s1_bc);
   assign bd_x = W2'(s1_bd);

   // (a+bi)(c-di) = (ac+bd) + (bc-ad)i
   assign sum_re = s1_conj ? (ac_x + bd_x) : (ac_x - bd_x);
   assign sum_im = s1_conj ? (bc_x - ad_x) : (ad_x + bc_x);

   cmul_round_sat #(.W2(W2), .F(F), .W(W), .RND(RND)) u_rs_re (
      .sum     (sum_re),
      .sum_rnd (rnd_re),
      .acc     (s2_re),
      .data    (sat_re),
      .ovf     (sat_ovf_re)
   );

   cmul_round_sat #(.W2(W2), .F(F), .W(W), .RND(RND)) u_rs_im (
      .sum     (sum_im),
      .sum_rnd (rnd_im),
      .acc     (s2_im),
      .data    (sat_im),
      .ovf     (sat_ovf_im)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_re    <= '0;
         s2_im    <= '0;
      end else if (bus.i_en) begin
         s2_valid <= s1_valid;
         s2_re    <= rnd_re;
         s2_im    <= rnd_im;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid  <= 1'b0;
         s3_re     <= '0;
         s3_im     <= '0;
         s3_ovf_re <= 1'b0;
         s3_ovf_im <= 1'b0;
      end else if (bus.i_en) begin
         s3_valid  <= s2_valid;
         s3_re     <= sat_re;
         s3_im     <= sat_im;
         s3_ovf_re <= s2_valid & sat_ovf_re;
         s3_ovf_im <= s2_valid & sat_ovf_im;
      end
   end

   // Clear is honoured even while frozen; a simultaneous new overflow wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (bus.i_en && s2_valid && (sat_ovf_re || sat_ovf_im)) begin
         ovf_sticky <= 1'b1;
      end else if (bus.i_clr_ovf) begin
         ovf_sticky <= 1'b0;
      end
   end

   assign bus.o_valid      = s3_valid;
   assign bus.o_data_re    = s3_re;
   assign bus.o_data_im    = s3_im;
   assign bus.o_ovf_re     = s3_ovf_re;
   assign bus.o_ovf_im     = s3_ovf_im;
   assign bus.o_ovf_sticky = ovf_sticky;

endmodule

// File: tb/tb_cmul_pipe.sv
// tb/tb_cmul_pipe.sv - self-checking bench for cmul_pipe in all three rounding modes
module tb_cmul_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmul_pipe_if #(.W(8)) bus0 ();
   cmul_pipe_if #(.W(8)) bus1 ();
   cmul_pipe_if #(.W(8)) bus2 ();

   cmul_pipe #(.I(4), .F(4), .RND(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   cmul_pipe #(.I(4), .F(4), .RND(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   cmul_pipe #(.I(4), .F(4), .RND(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int checks = 0;
   int errors = 0;

   // Reference pipeline: index [mode][stage], stage 2 is what the outputs should show.
   int pv [3];
   int pre[3][3];
   int pim[3][3];
   int pfr[3][3];
   int pfi[3][3];
   int st [3];

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Exact value x / 16 rounded per mode, then clamped to the 8-bit range.
   function automatic int rq(input int x, input int mode, output int ovf);
      int q, r;
      q = (x >= 0) ? x / 16 : -((15 - x) / 16);
      r = x - q * 16;
      if (mode == 1 && r >= 8) q++;
      if (mode == 2 && (r > 8 || (r == 8 && (q % 2) != 0))) q++;
      ovf = 0;
      if (q > 127)  begin q = 127;  ovf = 1; end
      if (q < -128) begin q = -128; ovf = 1; end
      return q;
   endfunction

   task automatic drive(input logic en, v, cj, input logic signed [7:0] a, b, c, d, input logic clr);
      bus0.i_en = en; bus0.i_valid = v; bus0.i_conj = cj; bus0.i_clr_ovf = clr;
      bus0.i_data1_re = a; bus0.i_data1_im = b; bus0.i_data2_re = c; bus0.i_data2_im = d;
      bus1.i_en = en; bus1.i_valid = v; bus1.i_conj = cj; bus1.i_clr_ovf = clr;
      bus1.i_data1_re = a; bus1.i_data1_im = b; bus1.i_data2_re = c; bus1.i_data2_im = d;
      bus2.i_en = en; bus2.i_valid = v; bus2.i_conj = cj; bus2.i_clr_ovf = clr;
      bus2.i_data1_re = a; bus2.i_data1_im = b; bus2.i_data2_re = c; bus2.i_data2_im = d;
   endtask

   task automatic check_dut(input int k, input string nm, input logic v,
                            input logic signed [7:0] dre, dim, input logic fr, fi, sk);
      chk($sformatf("%s_valid", nm), v, pv[2]);
      chk($sformatf("%s_ovf_re", nm), fr, pfr[k][2]);
      chk($sformatf("%s_ovf_im", nm), fi, pfi[k][2]);
      chk($sformatf("%s_sticky", nm), sk, st[k]);
      if (pv[2] != 0) begin
         chk($sformatf("%s_re", nm), dre, pre[k][2]);
         chk($sformatf("%s_im", nm), dim, pim[k][2]);
      end
   endtask

   task automatic step(input logic en, v, cj, input logic signed [7:0] a, b, c, d,
                       input logic clr, input logic r);
      int xr, xi, f;
      drive(en, v, cj, a, b, c, d, clr);
      rst = r;
      xr = cj ? (int'(a) * int'(c) + int'(b) * int'(d)) : (int'(a) * int'(c) - int'(b) * int'(d));
      xi = cj ? (int'(b) * int'(c) - int'(a) * int'(d)) : (int'(a) * int'(d) + int'(b) * int'(c));
      @(posedge clk);
      #1;
      if (r) begin
         for (int s = 0; s < 3; s++) pv[s] = 0;
         for (int k = 0; k < 3; k++) begin
            st[k] = 0;
            for (int s = 0; s < 3; s++) begin
               pre[k][s] = 0; pim[k][s] = 0; pfr[k][s] = 0; pfi[k][s] = 0;
            end
         end
      end else begin
         if (en) begin
            pv[2] = pv[1]; pv[1] = pv[0]; pv[0] = v ? 1 : 0;
            for (int k = 0; k < 3; k++) begin
               for (int s = 2; s > 0; s--) begin
                  pre[k][s] = pre[k][s-1]; pim[k][s] = pim[k][s-1];
                  pfr[k][s] = pfr[k][s-1]; pfi[k][s] = pfi[k][s-1];
               end
               pre[k][0] = 0; pim[k][0] = 0; pfr[k][0] = 0; pfi[k][0] = 0;
               if (v) begin
                  pre[k][0] = rq(xr, k, f); pfr[k][0] = f;
                  pim[k][0] = rq(xi, k, f); pfi[k][0] = f;
               end
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (en && pv[2] != 0 && (pfr[k][2] != 0 || pfi[k][2] != 0)) st[k] = 1;
            else if (clr) st[k] = 0;
         end
      end
      check_dut(0, "rnd0", bus0.o_valid, bus0.o_data_re, bus0.o_data_im, bus0.o_ovf_re, bus0.o_ovf_im, bus0.o_ovf_sticky);
      check_dut(1, "rnd1", bus1.o_valid, bus1.o_data_re, bus1.o_data_im, bus1.o_ovf_re, bus1.o_ovf_im, bus1.o_ovf_sticky);
      check_dut(2, "rnd2", bus2.o_valid, bus2.o_data_re, bus2.o_data_im, bus2.o_ovf_re, bus2.o_ovf_im, bus2.o_ovf_sticky);
   endtask

   task automatic feed(input logic cj, input logic signed [7:0] a, b, c, d);
      step(1'b1, 1'b1, cj, a, b, c, d, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic clr);
      step(1'b1, 1'b0, 1'b0, 8'sh00, 8'sh00, 8'sh00, 8'sh00, clr, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_valid"}, bus1.o_valid, 0);
      chk({nm, "_re"}, bus1.o_data_re, 0);
      chk({nm, "_im"}, bus1.o_data_im, 0);
      chk({nm, "_ovf_re"}, bus1.o_ovf_re, 0);
      chk({nm, "_ovf_im"}, bus1.o_ovf_im, 0);
      chk({nm, "_sticky"}, bus1.o_ovf_sticky, 0);
   endtask

   initial begin
      step(1'b1, 1'b0, 1'b0, 8'sh00, 8'sh00, 8'sh00, 8'sh00, 1'b0, 1'b1);
      chk_reset_outputs("reset_init");
      idle(1'b0);

      // (1.5+2i) * 2
      feed(1'b0, 8'sh18, 8'sh20, 8'sh20, 8'sh00); idle(1'b0); idle(1'b0);
      chk("basic_valid", bus1.o_valid, 1);
      chk("basic_re", bus1.o_data_re, 8'sh30);
      chk("basic_im", bus1.o_data_im, 8'sh40);
      chk("basic_ovf", {bus1.o_ovf_re, bus1.o_ovf_im}, 0);

      feed(1'b1, 8'sh10, 8'sh10, 8'sh10, 8'sh10);
      feed(1'b0, 8'sh10, 8'sh10, 8'sh10, 8'sh10); idle(1'b0);
      chk("conj_re", bus1.o_data_re, 8'sh20);
      chk("conj_im", bus1.o_data_im, 8'sh00);
      idle(1'b0);
      chk("noconj_re", bus1.o_data_re, 8'sh00);
      chk("noconj_im", bus1.o_data_im, 8'sh20);

      feed(1'b0, 8'sh70, 8'sh70, 8'sh70, 8'sh70); idle(1'b0); idle(1'b0);
      chk("sat_im", bus1.o_data_im, 8'sh7F);
      chk("sat_ovf_im", bus1.o_ovf_im, 1);
      chk("sat_sticky", bus1.o_ovf_sticky, 1);
      feed(1'b0, 8'sh80, 8'sh00, 8'sh80, 8'sh00); idle(1'b0); idle(1'b0);
      chk("neg_sat_re", bus1.o_data_re, 8'sh7F);
      chk("neg_sat_ovf_re", bus1.o_ovf_re, 1);

      feed(1'b0, 8'sh70, 8'sh70, 8'sh70, 8'sh70); idle(1'b0); idle(1'b1);
      chk("clr_vs_set_sticky", bus1.o_ovf_sticky, 1);
      idle(1'b1);
      chk("clr_sticky", bus1.o_ovf_sticky, 0);
      feed(1'b0, 8'sh70, 8'sh70, 8'sh70, 8'sh70); idle(1'b0); idle(1'b0);
      step(1'b0, 1'b0, 1'b0, 8'sh00, 8'sh00, 8'sh00, 8'sh00, 1'b1, 1'b0);
      chk("clr_frozen_sticky", bus1.o_ovf_sticky, 0);
      chk("clr_frozen_hold_im", bus1.o_data_im, 8'sh7F);

      feed(1'b0, 8'sh01, 8'sh00, 8'sh08, 8'sh00);
      feed(1'b0, 8'sh03, 8'sh00, 8'sh08, 8'sh00);
      feed(1'b0, 8'shFF, 8'sh00, 8'sh08, 8'sh00);
      chk("rnd0_p05", bus0.o_data_re, 8'sh00);
      chk("rnd1_p05", bus1.o_data_re, 8'sh01);
      chk("rnd2_p05", bus2.o_data_re, 8'sh00);
      idle(1'b0);
      chk("rnd0_p15", bus0.o_data_re, 8'sh01);
      chk("rnd1_p15", bus1.o_data_re, 8'sh02);
      chk("rnd2_p15", bus2.o_data_re, 8'sh02);
      idle(1'b0);
      chk("rnd0_m05", bus0.o_data_re, -8'sh01);
      chk("rnd1_m05", bus1.o_data_re, 8'sh00);
      chk("rnd2_m05", bus2.o_data_re, 8'sh00);
      idle(1'b0);

      // Valid pattern 1,0,1 with a two-cycle freeze in flight.
      feed(1'b0, 8'sh18, 8'sh00, 8'sh20, 8'sh00);
      idle(1'b0);
      step(1'b0, 1'b1, 1'b0, 8'sh55, 8'sh55, 8'sh55, 8'sh55, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'sh55, 8'sh55, 8'sh55, 8'sh55, 1'b0, 1'b0);
      chk("stall_no_early_valid", bus1.o_valid, 0);
      feed(1'b0, 8'sh10, 8'sh00, 8'sh10, 8'sh10);
      chk("stall_first_valid", bus1.o_valid, 1);
      chk("stall_first_re", bus1.o_data_re, 8'sh30);
      idle(1'b0);
      chk("stall_bubble", bus1.o_valid, 0);
      idle(1'b0);
      chk("stall_second_valid", bus1.o_valid, 1);
      chk("stall_second_im", bus1.o_data_im, 8'sh10);

      feed(1'b0, 8'sh70, 8'sh70, 8'sh70, 8'sh70);
      feed(1'b0, 8'sh11, 8'sh22, 8'sh33, 8'sh44);
      feed(1'b1, 8'sh80, 8'sh80, 8'sh80, 8'sh80);
      step(1'b1, 1'b1, 1'b0, 8'sh10, 8'sh10, 8'sh10, 8'sh10, 1'b0, 1'b1);
      chk_reset_outputs("reset_mid");
      for (int n = 0; n < 4; n++) begin
         idle(1'b0);
         chk("reset_no_stale", bus1.o_valid, 0);
      end

      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmul_pipe.md
# cmul_pipe

Parametrised, signed, fully pipelined complex multiplier for the FFT datapath, used for butterfly twiddle multiplication and spectrum post-processing. It replaces the fixed 8-bit, unsigned-product multiplier with the following additions:
- two's-complement Q(I).F operands of configurable width;
- valid tracking through a stallable pipeline;
- a per-sample conjugate mode;
- selectable rounding;
- saturation, with per-sample and sticky overflow flags.

## Interface
Parameters:
- I, 4, integer bits including sign (I ≥ 1)
- F, 4, fractional bits (F ≥ 1)
- RND, 1, rounding mode: 0 truncate (floor), 1 round-half-up, 2 round-half-to-even

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_en  in  1  pipeline advance enable; 0 freezes every register
- i_valid  in  1  operands present this cycle
- i_conj  in  1  1: multiply by conj(op2)
- i_data1_re, i_data1_im  in  I+F  operand 1 (a + bi), signed Q(I).F
- i_data2_re, i_data2_im  in  I+F  operand 2 (c + di), signed Q(I).F
- i_clr_ovf  in  1  clears o_ovf_sticky
- o_valid  out  1  result valid
- o_data_re, o_data_im  out  I+F  result, signed Q(I).F, saturated
- o_ovf_re, o_ovf_im  out  1  this result's component saturated
- o_ovf_sticky  out  1  any saturation since last reset or clear

## Operation
- Let W = I+F. All arithmetic is signed.
- **Stage 1.** Register the four 2W-bit products ac, ad, bc, bd, together with valid and conj.
- **Stage 2.** Combine at full precision, W2 = 2W+1 bits, with 2F fractional bits:
  - conj=0: re = ac − bd, im = ad + bc.
  - conj=1: re = ac + bd, im = bc − ad.
  - Add the rounding term and register. The rounding term is:
    - RND 0: zero.
    - RND 1: 2^(F−1).
    - RND 2: 2^(F−1), except zero when the discarded bits [F−1:0] equal exactly 2^(F−1) and bit F is 0.
  - Headroom for the rounding add is included in W2, so it never wraps.
- **Stage 3.** Arithmetic shift right by F, then saturate to W bits:
  - above 2^(W−1)−1 → 2^(W−1)−1, with the ovf bit set;
  - below −2^(W−1) → −2^(W−1), with the ovf bit set.
- o_ovf_re and o_ovf_im are qualified by valid. They are 0 whenever the stage-3 valid is 0.
- o_ovf_sticky:
  - sets when o_valid is registered 1 together with any ovf bit;
  - clears on i_clr_ovf;
  - if a clear and a new overflow occur in the same cycle, the set wins;
  - i_clr_ovf takes effect regardless of i_en.
- Data registers of invalid samples may hold don't-care values. Outputs must not change unless i_en=1.

## Timing
- Latency is exactly 3 enabled cycles: a sample accepted on edge k with i_en=1 appears at o_* after the 3rd edge with i_en=1, counting from k.
- Throughput is one sample per enabled cycle. No backpressure output.
- i_en=0: all pipeline stages, o_valid and o_data_* hold. Bubbles (i_valid=0) propagate as o_valid=0.
- Reset: every pipeline register and every output reads 0 after the first rst edge. This includes o_valid, o_data_re, o_data_im, o_ovf_re, o_ovf_im and o_ovf_sticky.
- rst dominates i_en. Reset mid-stream discards all in-flight samples; the first valid output afterwards appears no earlier than 3 enabled cycles after the first post-reset input.

## Structure
- Shared package fft_pkg holds the RND_TRUNC, RND_HALF_UP and RND_HALF_EVEN constants and a W-bit signed Q-format width helper.
- One sub-module, cmul_round_sat (parameters W2, F, W, RND), holds the rounding-term logic plus shift/saturate. It is instantiated twice, once for re and once for im.
- The stage registers stay in cmul_pipe.

## Test plan
All cases use I=4, F=4, RND=1, i_en=1 unless noted.
- **Basic product.** a,b,c,d = 0x18,0x20,0x20,0x00 (1.5+2i)(2) → 3 cycles later o_valid=1, re=0x30, im=0x40, no ovf.
- **Conjugate.** conj=1, a,b,c,d = 0x10,0x10,0x10,0x10 → re=0x20, im=0x00. The same inputs with conj=0 give re=0x00, im=0x20.
- **Saturation and sticky flag.**
  - a,b,c,d = 0x70 each gives 0+98i → re=0x00, im=0x7F, o_ovf_im=1, o_ovf_sticky=1.
  - −8 × −8: a=c=0x80, b=d=0 → re=0x7F, o_ovf_re=1.
  - Pulse i_clr_ovf together with a new overflowing result → sticky stays 1.
  - Pulse i_clr_ovf alone → sticky goes to 0.
- **Rounding modes.** Operand pairs 0x01×0x08 (+0.5 LSB), 0x03×0x08 (+1.5 LSB) and 0xFF×0x08 (−0.5 LSB):
  - RND 0 → 0x00, 0x01, 0xFF
  - RND 1 → 0x01, 0x02, 0x00
  - RND 2 → 0x00, 0x02, 0x00
- **Stall and bubbles.** Input the valid pattern 1,0,1 with i_en low for 2 cycles mid-stream → outputs hold during the stall, and the output valid pattern is 1,0,1 with correct data and total latency 3+2.
- **Reset.** Assert rst for 1 cycle with 3 samples in flight → all outputs 0 the next cycle, and no stale o_valid pulse appears afterwards.
